// File: rtl/score_commit_ctrl.sv
// score_commit_ctrl: arbitrates the high-score table port between score commit and browse readback; SCORE_RECORD_FLAG_EN adds an old-record pre-read and new_record
module score_commit_ctrl #(
  parameter int SCORE_W = 16,
  parameter int HOLD_CYC = 2,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit_req,
  input  logic [1:0]         play_level,
  input  logic [SCORE_W-1:0] final_score,
  input  logic               browse_req,
  input  logic [1:0]         browse_level,
  output logic               hs_mode,
  output logic [1:0]         hs_level,
  output logic [SCORE_W-1:0] hs_in_score,
  input  logic [SCORE_W-1:0] hs_out_score,
  output logic               busy,
  output logic               commit_done,
  output logic               new_record,
  output logic               browse_valid,
  output logic [SCORE_W-1:0] disp_score,
  output logic               bad_level
);
  localparam int MAX_WAIT = HOLD_CYC > READ_LAT + 1 ? HOLD_CYC : READ_LAT + 1;
  localparam int CW = $clog2(MAX_WAIT) + 1;
`ifdef SCORE_RECORD_FLAG_EN
  typedef enum logic [2:0] {IDLE, PRE_RD, WRITE, POST_RD, DONE, BROWSE} state_t;
  localparam state_t FIRST = PRE_RD;
  logic [SCORE_W-1:0] old;
`else
  typedef enum logic [2:0] {IDLE, WRITE, POST_RD, DONE, BROWSE} state_t;
  localparam state_t FIRST = WRITE;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] lvl, lvl_n;
  logic [SCORE_W-1:0] score, score_n;
  logic cm_ok, br_ok, last;
  assign last = cnt == '0;
  assign cm_ok = commit_req && play_level != 2'd0;
  assign br_ok = !commit_req && browse_req && browse_level != 2'd0;
  assign lvl_n = state == IDLE ? (cm_ok ? play_level : browse_level) : lvl;
  assign score_n = state == IDLE ? final_score : score;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cm_ok ? FIRST : br_ok ? BROWSE : IDLE;
`ifdef SCORE_RECORD_FLAG_EN
      PRE_RD:  nxt = last ? WRITE : PRE_RD;
`endif
      WRITE:   nxt = last ? POST_RD : WRITE;
      POST_RD: nxt = last ? DONE : POST_RD;
      BROWSE:  nxt = last ? IDLE : BROWSE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lvl          <= '0;
      score        <= '0;
`ifdef SCORE_RECORD_FLAG_EN
      old          <= '0;
`endif
      hs_mode      <= 1'b1;
      hs_level     <= '0;
      hs_in_score  <= '0;
      busy         <= 1'b0;
      commit_done  <= 1'b0;
      new_record   <= 1'b0;
      browse_valid <= 1'b0;
      disp_score   <= '0;
      bad_level    <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? (nxt == WRITE ? CW'(HOLD_CYC - 1) : CW'(READ_LAT)) : last ? cnt : cnt - CW'(1);
      if (state == IDLE && nxt != IDLE) lvl <= lvl_n;
      if (state == IDLE && cm_ok) score <= final_score;
`ifdef SCORE_RECORD_FLAG_EN
      if (state == PRE_RD && last) old <= hs_out_score;
      new_record <= nxt == DONE && score > old;
`else
      new_record <= 1'b0;
`endif
      if ((state == POST_RD || state == BROWSE) && last) disp_score <= hs_out_score;
      if (nxt == WRITE) hs_in_score <= score_n;
      hs_mode      <= nxt != WRITE;
      hs_level     <= (nxt == IDLE || nxt == DONE) ? 2'd0 : lvl_n;
      busy         <= nxt != IDLE && nxt != DONE;
      commit_done  <= nxt == DONE;
      browse_valid <= state == BROWSE && last;
      bad_level    <= state == IDLE && (commit_req ? play_level == 2'd0 : browse_req && browse_level == 2'd0);
    end
  end
endmodule

// File: tb/tb_score_commit_ctrl.sv
// tb_score_commit_ctrl: directed vector bench for score_commit_ctrl against a behavioural high-score table
module tb_score_commit_ctrl;
  localparam int SW = 16, HOLD = 2, RL = 1;
`ifdef SCORE_RECORD_FLAG_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif
  logic clk = 0, rst_n = 0, commit_req = 0, browse_req = 0;
  logic [1:0] play_level = 0, browse_level = 0;
  logic [SW-1:0] final_score = 0;
  logic hs_mode, busy, commit_done, new_record, browse_valid, bad_level;
  logic [1:0] hs_level;
  logic [SW-1:0] hs_in_score, hs_out_score, disp_score;
  logic [SW-1:0] mem [4];
  int n_cmp = 0, n_bad = 0;
  int c_done, c_new, c_bv, c_bad, c_wr, c_busy, c_chg, first_done, wr_lvl, wr_sc;
  typedef struct {
    bit c; logic [1:0] pl; logic [SW-1:0] sc; bit b; logic [1:0] bl;
    int done; int nw; int bv; int disp; int bad;
  } vec_t;
  vec_t tv [11];
  score_commit_ctrl #(.SCORE_W(SW), .HOLD_CYC(HOLD), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .commit_req(commit_req), .play_level(play_level),
    .final_score(final_score), .browse_req(browse_req), .browse_level(browse_level),
    .hs_mode(hs_mode), .hs_level(hs_level), .hs_in_score(hs_in_score),
    .hs_out_score(hs_out_score), .busy(busy), .commit_done(commit_done),
    .new_record(new_record), .browse_valid(browse_valid), .disp_score(disp_score),
    .bad_level(bad_level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!hs_mode && hs_in_score > mem[hs_level]) mem[hs_level] <= hs_in_score;
    hs_out_score <= mem[hs_level];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic req(bit c, logic [1:0] pl, logic [SW-1:0] sc, bit b, logic [1:0] bl);
    commit_req = c; play_level = pl; final_score = sc; browse_req = b; browse_level = bl;
    tick();
    commit_req = 0; browse_req = 0;
  endtask
  task automatic watch(int n, bit inj);
    c_done = 0; c_new = 0; c_bv = 0; c_bad = 0; c_wr = 0; c_busy = 0; c_chg = 0;
    first_done = -1; wr_lvl = -1; wr_sc = -1;
    for (int i = 1; i <= n; i++) begin
      if (commit_done) begin
        c_done++;
        if (first_done < 0) first_done = i;
        c_new += int'(new_record);
      end
      if (!hs_mode) begin
        if (wr_lvl < 0) begin wr_lvl = int'(hs_level); wr_sc = int'(hs_in_score); end
        else if (wr_lvl != int'(hs_level) || wr_sc != int'(hs_in_score)) c_chg++;
        c_wr++;
      end
      c_bv += int'(browse_valid); c_bad += int'(bad_level); c_busy += int'(busy);
      if (inj && i == 2) begin browse_req = 1; browse_level = 1; end
      if (inj && i == 3) begin commit_req = 1; play_level = 3; final_score = 999; end
      tick();
      commit_req = 0; browse_req = 0;
    end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    tv[0]  = '{1, 1, 300,   0, 0, 1, 0, 0, 500,   0};
    tv[1]  = '{0, 0, 0,     1, 1, 0, 0, 1, 500,   0};
    tv[2]  = '{0, 0, 0,     1, 3, 0, 0, 1, 0,     0};
    tv[3]  = '{1, 0, 999,   0, 0, 0, 0, 0, 0,     1};
    tv[4]  = '{0, 0, 0,     1, 0, 0, 0, 0, 0,     1};
    tv[5]  = '{1, 3, 65535, 0, 0, 1, 1, 0, 65535, 0};
    tv[6]  = '{1, 3, 65535, 0, 0, 1, 0, 0, 65535, 0};
    tv[7]  = '{0, 0, 0,     1, 2, 0, 0, 1, 700,   0};
    tv[8]  = '{1, 2, 701,   0, 0, 1, 1, 0, 701,   0};
    tv[9]  = '{1, 2, 700,   0, 0, 1, 0, 0, 701,   0};
    tv[10] = '{1, 1, 501,   1, 2, 1, 1, 0, 501,   0};
    repeat (3) tick();
    check("rst hs_mode", int'(hs_mode), 1);
    check("rst hs_level", int'(hs_level), 0);
    check("rst hs_in_score", int'(hs_in_score), 0);
    check("rst busy", int'(busy), 0);
    check("rst pulses", int'({commit_done, new_record, browse_valid, bad_level}), 0);
    check("rst disp_score", int'(disp_score), 0);
    rst_n = 1;
    tick();
    req(1, 1, 500, 0, 0);
    watch(14, 0);
    check("A done count", c_done, 1);
    check("A done latency", first_done, HOLD + RL + 2 + (REC ? RL + 1 : 0));
    check("A new_record", c_new, int'(REC));
    check("A disp_score", int'(disp_score), 500);
    check("A write cycles", c_wr, HOLD);
    check("A write level", wr_lvl, 1);
    check("A write score", wr_sc, 500);
    check("A write stable", c_chg, 0);
    req(1, 2, 700, 1, 3);
    watch(14, 1);
    check("B done count", c_done, 1);
    check("B browse_valid", c_bv, 0);
    check("B disp_score", int'(disp_score), 700);
    check("B new_record", c_new, int'(REC));
    for (int k = 0; k < 11; k++) begin
      req(tv[k].c, tv[k].pl, tv[k].sc, tv[k].b, tv[k].bl);
      watch(14, 0);
      check($sformatf("v%0d done", k), c_done, tv[k].done);
      check($sformatf("v%0d new_record", k), c_new, tv[k].nw & int'(REC));
      check($sformatf("v%0d browse_valid", k), c_bv, tv[k].bv);
      check($sformatf("v%0d bad_level", k), c_bad, tv[k].bad);
      check($sformatf("v%0d disp_score", k), int'(disp_score), tv[k].disp);
      check($sformatf("v%0d write cycles", k), c_wr, tv[k].done != 0 ? HOLD : 0);
      check($sformatf("v%0d busy cycles", k), c_busy,
            tv[k].done != 0 ? HOLD + RL + 1 + (REC ? RL + 1 : 0) : tv[k].bv != 0 ? RL + 1 : 0);
    end
    req(1, 1, 900, 0, 0);
    repeat (REC ? RL + 1 : 0) tick();
    check("C in write", int'(hs_mode), 0);
    rst_n = 0;
    tick();
    check("C busy", int'(busy), 0);
    check("C hs_mode", int'(hs_mode), 1);
    check("C hs_level", int'(hs_level), 0);
    rst_n = 1;
    watch(10, 0);
    check("C no done", c_done, 0);
    check("C idle", c_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
